// File: rtl/mips_muldiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
// Op encoding matches the core's funct decode.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } muldiv_state_t;

  function automatic logic is_signed(muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_muldiv(muldiv_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Command/result bundle between the core (master) and the muldiv unit (slave).
interface mips_muldiv_unit_if #(parameter int WIDTH = 32);
  import mips_muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, op_a, op_b, input busy, done, hi, lo);
  modport slave  (input start, op, op_a, op_b, output busy, done, hi, lo);

endinterface

// File: rtl/mips_muldiv_unit_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mips_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The remainder stays below the divisor, so the top diff bit is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with single-cycle MTHI/MTLO.
// Works on magnitudes during RUN and applies signs once in FIX.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  mips_muldiv_unit_if.slave  bus
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = $clog2(N + 1);

  if (((WIDTH % STEP_BITS) != 0) ||
      !((STEP_BITS == 1) || (STEP_BITS == 2) || (STEP_BITS == 4))) begin : g_bad_cfg
    $error("mips_muldiv_unit: STEP_BITS must be 1, 2 or 4 and divide WIDTH");
  end

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] raw_a_q, raw_a_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;

  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH-1:0] div_rem, div_quo;
  logic [2*WIDTH-1:0] prod;

  assign op_signed = is_signed(bus.op);
  assign a_neg     = op_signed & bus.op_a[WIDTH-1];
  assign b_neg     = op_signed & bus.op_b[WIDTH-1];
  assign prod      = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  // Shift-add multiply: acc_lo holds the unconsumed multiplier bits, acc_hi the partial sum.
  always_comb begin
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mh, ml;
    mh  = acc_hi_q;
    ml  = acc_lo_q;
    sum = '0;
    for (int k = 0; k < STEP_BITS; k++) begin
      sum = {1'b0, mh} + (ml[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      ml  = {sum[0], ml[WIDTH-1:1]};
      mh  = sum[WIDTH:1];
    end
    mul_hi = mh;
    mul_lo = ml;
  end

  for (genvar k = 0; k < STEP_BITS; k++) begin : g_div
    logic [WIDTH-1:0] rem_i, quo_i, rem_o, quo_o;
    if (k == 0) begin : g_first
      assign rem_i = acc_hi_q;
      assign quo_i = acc_lo_q;
    end else begin : g_next
      assign rem_i = g_div[k-1].rem_o;
      assign quo_i = g_div[k-1].quo_o;
    end
    mips_divstep #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_i),
      .quo_in  (quo_i),
      .divisor (b_q),
      .rem_out (rem_o),
      .quo_out (quo_o)
    );
  end

  assign div_rem = g_div[STEP_BITS-1].rem_o;
  assign div_quo = g_div[STEP_BITS-1].quo_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    b_d       = b_q;
    raw_a_d   = raw_a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.op)) begin
            state_d   = RUN;
            busy_d    = 1'b1;
            cnt_d     = '0;
            acc_hi_d  = '0;
            acc_lo_d  = a_neg ? -bus.op_a : bus.op_a;
            b_d       = b_neg ? -bus.op_b : bus.op_b;
            raw_a_d   = bus.op_a;
            is_div_d  = (bus.op == DIV) || (bus.op == DIVU);
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            div0_d    = (bus.op_b == '0);
          end else if (bus.op == MTHI) begin
            hi_d = bus.op_a;
          end else if (bus.op == MTLO) begin
            lo_d = bus.op_a;
          end
        end
      end
      RUN: begin
        acc_hi_d = is_div_q ? div_rem : mul_hi;
        acc_lo_d = is_div_q ? div_quo : mul_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
          lo_d = neg_q ? -acc_lo_q : acc_lo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The core's enable also gates reset, so a stalled core keeps even a pending reset off.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (reset) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        hi_q      <= '0;
        lo_q      <= '0;
        acc_hi_q  <= '0;
        acc_lo_q  <= '0;
        b_q       <= '0;
        raw_a_q   <= '0;
        is_div_q  <= 1'b0;
        neg_q     <= 1'b0;
        rem_neg_q <= 1'b0;
        div0_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        busy_q    <= busy_d;
        done_q    <= done_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        acc_hi_q  <= acc_hi_d;
        acc_lo_q  <= acc_lo_d;
        b_q       <= b_d;
        raw_a_q   <= raw_a_d;
        is_div_q  <= is_div_d;
        neg_q     <= neg_d;
        rem_neg_q <= rem_neg_d;
        div0_q    <= div0_d;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: an arithmetic reference model queues
// expected HI/LO results at acceptance and a negedge monitor checks the DUT.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int WIDTH     = 32;
  localparam int STEP_BITS = 1;
  localparam int N         = WIDTH / STEP_BITS;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;

  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  mips_muldiv_unit #(.WIDTH(WIDTH), .STEP_BITS(STEP_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: architectural HI/LO plus a countdown of enabled edges.
  int          remaining  = 0;
  int          model_tick = 0;
  logic        model_done = 1'b0;
  logic [31:0] arch_hi    = '0;
  logic [31:0] arch_lo    = '0;
  result_t     pending    = '0;
  result_t     exp_q[$];

  int  last_tick = 0;
  bit  checking  = 1'b0;

  function automatic result_t refResult(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
    result_t     r;
    longint      sa, sb, q, m;
    logic [63:0] p, qv, mv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      MULT: begin
        p = 64'(sa * sb);
        r = {p[63:32], p[31:0]};
      end
      MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        r = {p[63:32], p[31:0]};
      end
      DIV: begin
        if (b == 0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
        end else begin
          q    = sa / sb;
          m    = sa % sb;
          qv   = 64'(q);
          mv   = 64'(m);
          r.lo = qv[31:0];
          r.hi = mv[31:0];
        end
      end
      DIVU: begin
        if (b == 0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (clk_enable) begin
      model_tick <= model_tick + 1;
      model_done <= 1'b0;
      if (reset) begin
        remaining <= 0;
        arch_hi   <= '0;
        arch_lo   <= '0;
        exp_q.delete();
      end else if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          arch_hi    <= pending.hi;
          arch_lo    <= pending.lo;
          model_done <= 1'b1;
        end
      end else if (bus.start) begin
        case (bus.op)
          MTHI: arch_hi <= bus.op_a;
          MTLO: arch_lo <= bus.op_a;
          MULT, MULTU, DIV, DIVU: begin
            pending   <= refResult(bus.op, bus.op_a, bus.op_b);
            exp_q.push_back(refResult(bus.op, bus.op_a, bus.op_b));
            remaining <= N + 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: handshake and HI/LO every cycle, scoreboard pop on each new done.
  always @(negedge clk) begin
    result_t e;
    if (checking) begin
      checkOutput("busy", 64'(bus.busy), 64'(remaining != 0));
      checkOutput("done", 64'(bus.done), 64'(model_done));
      if (bus.done && (model_tick != last_tick)) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("result_hi", 64'(bus.hi), 64'(e.hi));
          checkOutput("result_lo", 64'(bus.lo), 64'(e.lo));
        end else begin
          compared++;
          mismatched++;
          $display("[TB] FAIL result: done seen with no queued result at %0t", $time);
        end
      end
      checkOutput("hi", 64'(bus.hi), 64'(arch_hi));
      checkOutput("lo", 64'(bus.lo), 64'(arch_lo));
    end
    last_tick <= model_tick;
  end

  task automatic applyStimulus(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    clk_enable = 1'b1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.op_a   = a;
    bus.op_b   = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic waitIdle(bit noisy);
    int guard = 0;
    while ((remaining != 0) && (guard < 2000)) begin
      @(negedge clk);
      guard++;
      bus.start  = 1'b0;
      clk_enable = 1'b1;
      if (noisy && (remaining != 0)) begin
        clk_enable = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) == 0) begin
          bus.start = 1'b1;
          bus.op    = muldiv_op_t'($urandom_range(0, 5));
          bus.op_a  = $urandom;
          bus.op_b  = $urandom;
        end
      end
    end
    if (remaining != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_wait: model still busy after %0d cycles", guard);
    end
    bus.start  = 1'b0;
    clk_enable = 1'b1;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    reset      = 1'b1;
    clk_enable = 1'b1;
    bus.start  = 1'b0;
    bus.op     = MULT;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_hi", 64'(bus.hi), 64'h0);
    checkOutput("reset_busy", 64'(bus.busy), 64'h0);
    reset = 1'b0;

    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle(1'b0);
    checkOutput("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    checkOutput("multu_max_lo", 64'(bus.lo), 64'h0000_0001);

    applyStimulus(MULT, -32'sd3, 32'd7);
    waitIdle(1'b0);
    checkOutput("mult_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    checkOutput("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);

    applyStimulus(DIV, -32'sd7, 32'd2);
    waitIdle(1'b0);
    checkOutput("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    checkOutput("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    applyStimulus(DIVU, 32'd7, 32'd0);
    waitIdle(1'b0);
    checkOutput("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    checkOutput("div0_hi", 64'(bus.hi), 64'h0000_0007);

    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(1'b0);
    checkOutput("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    checkOutput("div_ovf_hi", 64'(bus.hi), 64'h0);

    // A second start during RUN is dropped; a start in the done cycle is taken.
    applyStimulus(MULTU, 32'd3, 32'd5);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = DIVU;
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!model_done && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("busy_ignore_hi", 64'(bus.hi), 64'h0);
    checkOutput("busy_ignore_lo", 64'(bus.lo), 64'd15);
    bus.start = 1'b1;
    bus.op    = DIVU;
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle(1'b0);
    checkOutput("done_cycle_lo", 64'(bus.lo), 64'd14);
    checkOutput("done_cycle_hi", 64'(bus.hi), 64'd2);

    // Reset in the middle of a divide aborts it and clears HI/LO.
    applyStimulus(DIV, 32'($urandom), 32'($urandom) | 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(bus.busy), 64'h0);
    checkOutput("abort_done", 64'(bus.done), 64'h0);
    checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'h0);
    repeat (N + 5) @(negedge clk);

    applyStimulus(MTHI, 32'h0000_1234, 32'd0);
    checkOutput("mthi_hi", 64'(bus.hi), 64'h1234);
    applyStimulus(MTLO, 32'h0000_ABCD, 32'd0);
    checkOutput("mtlo_lo", 64'(bus.lo), 64'hABCD);
    checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'h1234);

    // Ten disabled cycles mid-multiply push the done edge out by ten.
    applyStimulus(MULT, 32'hFFFF_FFF9, 32'h0001_0003);
    repeat (5) @(negedge clk);
    clk_enable = 1'b0;
    repeat (10) @(negedge clk);
    clk_enable = 1'b1;
    waitIdle(1'b0);

    repeat (60) begin
      applyStimulus(muldiv_op_t'($urandom_range(0, 5)), pickOperand(), pickOperand());
      waitIdle(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
